neuron_mac: RTL and testbench
=============================

// Module: neuron_mac
// PURPOSE
//   Per-neuron multiply-accumulate stage directly upstream of the sigmoid wrapper.
//   Streams N_INPUTS (activation, weight) pairs over a valid/ready handshake and
//   accumulates their signed products on top of a preloaded bias, with saturation.
//   Presents the 22-bit signed Q8.14 sum on mout, which feeds the wrapper's mout input.
// PARAMETERS
//   N_INPUTS  784  pairs accumulated per neuron evaluation (>=2)
//   ACT_W     8    activation width, unsigned Q0.8 (same format as sig_out)
//   WGT_W     8    weight width, signed Q2.6
//   ACC_W     22   accumulator/mout width, signed Q8.14
//   CNT_W     10   beat counter width, >= $clog2(N_INPUTS)
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   start       in   1      pulse: begin evaluation (sampled only in IDLE)
//   bias        in   ACC_W  signed Q8.14, latched on start
//   in_valid    in   1      act/wgt valid
//   in_ready    out  1      stage accepts a pair
//   act         in   ACT_W  activation
//   wgt         in   WGT_W  weight
//   mout        out  ACC_W  accumulated result to sigmoid wrapper
//   mout_valid  out  1      mout holds a final result
//   mout_ready  in   1      consumer takes mout
//   busy        out  1      state != IDLE
//   sat         out  1      sticky: saturation occurred this evaluation
// BEHAVIOUR
//   Reset: state IDLE; acc, mout, count, prod, prod_v, sat, mout_valid, in_ready, busy = 0.
//   Reset mid-operation aborts at once; no partial mout_valid is produced.
//   FSM: IDLE -start-> ACCUM -last beat accepted-> DRAIN -> DONE -mout_ready-> IDLE.
//   IDLE: in_ready=0. On start: acc<=bias, count<=0, sat<=0, prod_v<=0.
//   start outside IDLE (including DONE with mout_ready) is ignored.
//   ACCUM: in_ready=1. A beat transfers when in_valid & in_ready.
//   Stage 1 (beat edge): prod <= $signed({1'b0,act}) * $signed(wgt); prod is 16-bit Q2.14.
//     prod_v <= 1, count++.
//   Stage 1 (no-beat edge): prod_v <= 0 (bubble; acc unchanged).
//   Stage 2 (edge after prod_v=1): acc <= sat_add(acc, sext(prod)).
//     Sum is formed in ACC_W+1 bits.
//     Positive overflow clamps to 0x1FFFFF; negative overflow clamps to 0x200000; sat<=1.
//   Last beat: the edge accepting beat with count==N_INPUTS-1 moves ACCUM->DRAIN.
//     in_ready drops in the next cycle.
//   DRAIN: one cycle; last product enters acc; ->DONE; mout<=updated acc.
//   Latency: the final handshake is edge t; mout_valid=1 from edge t+2.
//   DONE: mout_valid=1; mout and sat held stable while mout_ready=0.
//     On mout_ready: mout_valid<=0, ->IDLE. mout keeps its last value afterwards.
//   No output FIFO; single evaluation in flight.
// STRUCTURE
//   Shared package neuron_pkg holds:
//     ACT_W/WGT_W/ACC_W, FRAC_BITS=14, SAT_MAX=22'h1FFFFF, SAT_MIN=22'h200000,
//     and the state enum {IDLE, ACCUM, DRAIN, DONE}.
//   One sub-module, sat_add (ACC_W signed saturating adder with ovf flag), instantiated once.
//   FSM, counter and product register stay in neuron_mac.
// TESTING (bench overrides N_INPUTS=4)
//   1 Reset: assert rst mid-cycle -> all outputs 0 immediately; busy=0.
//   2 Basic: bias=0, 4 beats act=255 wgt=64, back-to-back
//       -> mout=0x00FF00, sat=0, mout_valid at edge t+2.
//   3 Pos sat: bias=0x1FF000, 4 beats act=255 wgt=127 -> mout=0x1FFFFF, sat=1.
//   4 Neg sat: bias=0x200400, 4 beats act=255 wgt=-128 -> mout=0x200000, sat=1.
//   5 Flow: repeat test 2 with in_valid toggling 1-0-1 and mout_ready low for 5 cycles
//       -> mout=0x00FF00, stable while held; start pulses in DONE ignored.
//   6 Abort: rst after 2 beats, then a fresh start, bias=0x000100, 4 beats act=1 wgt=1
//       -> mout=0x000104, mout_valid never seen before the restart.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared widths, saturation limits and FSM encoding for the neuron MAC stage.
package neuron_pkg;
  localparam int ACT_W     = 8;
  localparam int WGT_W     = 8;
  localparam int ACC_W     = 22;
  localparam int FRAC_BITS = 14;
  localparam logic [ACC_W-1:0] SAT_MAX = 22'h1FFFFF;
  localparam logic [ACC_W-1:0] SAT_MIN = 22'h200000;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
endpackage

// File: rtl/neuron_mac_sat_add.sv
// Signed saturating adder: clamps to the most positive/negative code and flags overflow.
module sat_add
  import neuron_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);
  logic [W:0] sum;

  always_comb begin
    sum = {a[W-1], a} + {b[W-1], b};
    ovf = sum[W] ^ sum[W-1];
    y   = sum[W-1:0];
    // The extra top bit holds the true sign of the result.
    if (ovf) y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
endmodule

// File: rtl/neuron_mac.sv
// Streams (activation, weight) pairs, accumulates products onto a bias with saturation,
// and presents the Q8.14 sum to the sigmoid wrapper over a valid/ready handshake.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 784,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACT_W-1:0] act,
  input  logic [WGT_W-1:0] wgt,
  output logic [ACC_W-1:0] mout,
  output logic             mout_valid,
  input  logic             mout_ready,
  output logic             busy,
  output logic             sat
);
  localparam int PROD_W = ACT_W + WGT_W;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mout_q, mout_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               prod_v_q, prod_v_d;
  logic               sat_q, sat_d;
  logic               mout_valid_q, mout_valid_d;

  logic               beat;
  logic [PROD_W-1:0]  act_x, wgt_x;
  logic [ACC_W-1:0]   add_y;
  logic               add_ovf;

  assign in_ready   = (state_q == ACCUM);
  assign busy       = (state_q != IDLE);
  assign mout       = mout_q;
  assign mout_valid = mout_valid_q;
  assign sat        = sat_q;
  assign beat       = in_valid && in_ready;

  // Activation is unsigned, weight signed; both widened so the product is exact.
  assign act_x = {{(PROD_W-ACT_W){1'b0}}, act};
  assign wgt_x = {{(PROD_W-WGT_W){wgt[WGT_W-1]}}, wgt};

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   ({{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q}),
    .y   (add_y),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mout_d       = mout_q;
    count_d      = count_q;
    prod_d       = prod_q;
    prod_v_d     = 1'b0;
    sat_d        = sat_q;
    mout_valid_d = mout_valid_q;

    if (prod_v_q) begin
      acc_d = add_y;
      if (add_ovf) sat_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = bias;
          count_d  = '0;
          sat_d    = 1'b0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          prod_d   = act_x * wgt_x;
          prod_v_d = 1'b1;
          count_d  = count_q + CNT_W'(1);
          if (count_q == CNT_W'(N_INPUTS-1)) state_d = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        // acc settled on the DRAIN edge; publish it one edge later.
        if (!mout_valid_q) begin
          mout_d       = acc_q;
          mout_valid_d = 1'b1;
        end else if (mout_ready) begin
          mout_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      mout_q       <= '0;
      count_q      <= '0;
      prod_q       <= '0;
      prod_v_q     <= 1'b0;
      sat_q        <= 1'b0;
      mout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mout_q       <= mout_d;
      count_q      <= count_d;
      prod_q       <= prod_d;
      prod_v_q     <= prod_v_d;
      sat_q        <= sat_d;
      mout_valid_q <= mout_valid_d;
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with a 4-input neuron.
module tb_neuron_mac;
  localparam int N  = 4;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] bias = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    act = '0;
  logic [7:0]    wgt = '0;
  logic [AW-1:0] mout;
  logic          mout_valid;
  logic          mout_ready = 1'b0;
  logic          busy;
  logic          sat;

  int errors = 0;
  int checks = 0;

  neuron_mac #(.N_INPUTS(N), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .act(act), .wgt(wgt),
    .mout(mout), .mout_valid(mout_valid), .mout_ready(mout_ready),
    .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] bias;
    logic [7:0]    act;
    logic [7:0]    wgt;
    logic [AW-1:0] exp_mout;
    logic          exp_sat;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One full evaluation; gaps toggles in_valid, hold keeps mout_ready low for that many cycles.
  task automatic run_eval(input string tag, input logic [AW-1:0] b, input logic [7:0] a,
                          input logic [7:0] w, input logic [AW-1:0] exp_m, input logic exp_s,
                          input bit gaps, input int hold, input bit release_out);
    int n;
    int cyc;
    bias  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " in_ready_accum"}, 32'(in_ready), 32'd1);
    n = 0;
    cyc = 0;
    while (n < N && cyc < 40) begin
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      act = a;
      wgt = w;
      if (in_valid && in_ready) n++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (n < N) chk({tag, " beat_timeout"}, 32'(n), 32'(N));
    chk({tag, " in_ready_drop"}, 32'(in_ready), 32'd0);
    chk({tag, " valid_t0"}, 32'(mout_valid), 32'd0);
    tick();
    chk({tag, " valid_t1"}, 32'(mout_valid), 32'd0);
    tick();
    chk({tag, " valid_t2"}, 32'(mout_valid), 32'd1);
    chk({tag, " mout"}, 32'(mout), 32'(exp_m));
    chk({tag, " sat"}, 32'(sat), 32'(exp_s));
    for (int i = 0; i < hold; i++) begin
      mout_ready = 1'b0;
      start = (i == 1);
      bias  = 22'h155555;
      tick();
      chk({tag, " hold_mout"}, 32'(mout), 32'(exp_m));
      chk({tag, " hold_valid"}, 32'(mout_valid), 32'd1);
      chk({tag, " hold_sat"}, 32'(sat), 32'(exp_s));
    end
    start = 1'b0;
    if (release_out) begin
      mout_ready = 1'b1;
      start = (hold > 0);
      tick();
      mout_ready = 1'b0;
      start = 1'b0;
      chk({tag, " valid_cleared"}, 32'(mout_valid), 32'd0);
      chk({tag, " busy_idle"}, 32'(busy), 32'd0);
      chk({tag, " mout_kept"}, 32'(mout), 32'(exp_m));
    end
  endtask

  initial begin
    vecs[0] = '{22'h000000, 8'd255, 8'd64,   22'h00FF00, 1'b0};
    vecs[1] = '{22'h1FF000, 8'd255, 8'd127,  22'h1FFFFF, 1'b1};
    vecs[2] = '{22'h200400, 8'd255, 8'h80,   22'h200000, 1'b1};
    vecs[3] = '{22'h3FFF00, 8'd2,   8'd64,   22'h000100, 1'b0};
    vecs[4] = '{22'h1FFFFF, 8'd0,   8'd127,  22'h1FFFFF, 1'b0};

    #12;
    chk("rst_mout", 32'(mout), 32'd0);
    chk("rst_valid", 32'(mout_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_eval($sformatf("vec%0d", i), vecs[i].bias, vecs[i].act, vecs[i].wgt,
               vecs[i].exp_mout, vecs[i].exp_sat, 1'b0, 0, 1'b1);

    run_eval("flow", 22'h000000, 8'd255, 8'd64, 22'h00FF00, 1'b0, 1'b1, 5, 1'b1);

    // Mid-cycle reset while a saturated result is waiting in DONE.
    run_eval("midrst", 22'h200400, 8'd255, 8'h80, 22'h200000, 1'b1, 1'b0, 0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_mout", 32'(mout), 32'd0);
    chk("midrst_valid", 32'(mout_valid), 32'd0);
    chk("midrst_sat", 32'(sat), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Abort after two beats, then a clean evaluation.
    bias  = 22'h0ABCDE;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    act = 8'd100;
    wgt = 8'd50;
    tick();
    tick();
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(mout_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_valid", 32'(mout_valid), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    run_eval("restart", 22'h000100, 8'd1, 8'd1, 22'h000104, 1'b0, 1'b0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
